// File: rtl/sc_psr.sv
// Processor status register: stores {N,Z,V,C} from ALU flag-setting ops, decodes branch
// conditions from the stored flags, raises an overflow trap, and counts overflow events.
module sc_psr #(
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATAWIDTH_CONDITION     = 4
) (
  input  logic                               SC_PSR_CLOCK_50,
  input  logic                               SC_PSR_RESET_InLow,
  input  logic                               SC_PSR_Negative_InHigh,
  input  logic                               SC_PSR_Zero_InHigh,
  input  logic                               SC_PSR_Overflow_InHigh,
  input  logic                               SC_PSR_Carry_InHigh,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] SC_PSR_ALUSelection_In,
  input  logic                               SC_PSR_Load_InHigh,
  input  logic [DATAWIDTH_CONDITION-1:0]     SC_PSR_Condition_In,
  input  logic                               SC_PSR_TrapEnable_InHigh,
  input  logic                               SC_PSR_TrapAck_InHigh,
  input  logic                               SC_PSR_CountClear_InHigh,
  output logic [3:0]                         SC_PSR_Flags_Out,
  output logic                               SC_PSR_BranchTaken_OutHigh,
  output logic                               SC_PSR_TrapRequest_OutHigh,
  output logic [3:0]                         SC_PSR_OverflowCount_Out
);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    RELEASE
  } trapState_t;

  trapState_t trapState, trapStateNext;
  logic [3:0] flags;
  logic [3:0] overflowCount;
  logic       isAddcc;
  logic       isFlagOp;
  logic       overflowEvent;
  logic       condBase;
  logic       flagN, flagZ, flagV, flagC;

  assign isAddcc       = (SC_PSR_ALUSelection_In == DATAWIDTH_ALU_SELECTION'(3));
  assign isFlagOp      = (SC_PSR_ALUSelection_In <  DATAWIDTH_ALU_SELECTION'(4));
  assign overflowEvent = SC_PSR_Load_InHigh & isAddcc & SC_PSR_Overflow_InHigh;

  always_ff @(posedge SC_PSR_CLOCK_50 or negedge SC_PSR_RESET_InLow) begin
    if (!SC_PSR_RESET_InLow) begin
      flags <= '0;
    end else if (SC_PSR_Load_InHigh && isFlagOp) begin
      if (isAddcc)
        flags <= {SC_PSR_Negative_InHigh, SC_PSR_Zero_InHigh,
                  SC_PSR_Overflow_InHigh, SC_PSR_Carry_InHigh};
      else
        flags <= {SC_PSR_Negative_InHigh, SC_PSR_Zero_InHigh, 2'b00};
    end
  end

  assign {flagN, flagZ, flagV, flagC} = flags;

  // Upper condition bit inverts the base test selected by the lower three bits.
  always_comb begin
    condBase = 1'b0;
    unique case (SC_PSR_Condition_In[2:0])
      3'd0: condBase = 1'b0;
      3'd1: condBase = flagZ;
      3'd2: condBase = flagZ | (flagN ^ flagV);
      3'd3: condBase = flagN ^ flagV;
      3'd4: condBase = flagC | flagZ;
      3'd5: condBase = flagC;
      3'd6: condBase = flagN;
      3'd7: condBase = flagV;
      default: condBase = 1'b0;
    endcase
    SC_PSR_BranchTaken_OutHigh = SC_PSR_RESET_InLow & (condBase ^ SC_PSR_Condition_In[3]);
  end

  always_ff @(posedge SC_PSR_CLOCK_50 or negedge SC_PSR_RESET_InLow) begin
    if (!SC_PSR_RESET_InLow)
      trapState <= IDLE;
    else
      trapState <= trapStateNext;
  end

  always_comb begin
    trapStateNext = trapState;
    unique case (trapState)
      IDLE:    if (overflowEvent && SC_PSR_TrapEnable_InHigh) trapStateNext = PENDING;
      PENDING: if (SC_PSR_TrapAck_InHigh)                     trapStateNext = RELEASE;
      RELEASE: if (!SC_PSR_TrapAck_InHigh)                    trapStateNext = IDLE;
      default: trapStateNext = IDLE;
    endcase
  end

  assign SC_PSR_TrapRequest_OutHigh = (trapState == PENDING);

  always_ff @(posedge SC_PSR_CLOCK_50 or negedge SC_PSR_RESET_InLow) begin
    if (!SC_PSR_RESET_InLow)
      overflowCount <= '0;
    else if (SC_PSR_CountClear_InHigh)
      overflowCount <= '0;
    else if (overflowEvent && (overflowCount != '1))
      overflowCount <= overflowCount + 4'd1;
  end

  assign SC_PSR_Flags_Out         = flags;
  assign SC_PSR_OverflowCount_Out = overflowCount;

endmodule

// File: tb/tb_sc_psr.sv
// Scoreboard bench for sc_psr: driver pushes model-predicted post-edge state,
// monitor pops and compares on the falling edge.
module tb_sc_psr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       inN = 1'b0, inZ = 1'b0, inV = 1'b0, inC = 1'b0;
  logic [3:0] aluSel = '0;
  logic       load = 1'b0;
  logic [3:0] cond = '0;
  logic       trapEn = 1'b0, trapAck = 1'b0, cntClr = 1'b0;
  logic [3:0] flagsOut;
  logic       branchOut, trapOut;
  logic [3:0] countOut;

  always #5 clk = ~clk;

  sc_psr #(.DATAWIDTH_ALU_SELECTION(4), .DATAWIDTH_CONDITION(4)) dut (
    .SC_PSR_CLOCK_50           (clk),
    .SC_PSR_RESET_InLow        (rst_n),
    .SC_PSR_Negative_InHigh    (inN),
    .SC_PSR_Zero_InHigh        (inZ),
    .SC_PSR_Overflow_InHigh    (inV),
    .SC_PSR_Carry_InHigh       (inC),
    .SC_PSR_ALUSelection_In    (aluSel),
    .SC_PSR_Load_InHigh        (load),
    .SC_PSR_Condition_In       (cond),
    .SC_PSR_TrapEnable_InHigh  (trapEn),
    .SC_PSR_TrapAck_InHigh     (trapAck),
    .SC_PSR_CountClear_InHigh  (cntClr),
    .SC_PSR_Flags_Out          (flagsOut),
    .SC_PSR_BranchTaken_OutHigh(branchOut),
    .SC_PSR_TrapRequest_OutHigh(trapOut),
    .SC_PSR_OverflowCount_Out  (countOut)
  );

  typedef struct packed {
    logic [3:0] flags;
    logic       trap;
    logic [3:0] count;
    logic       branch;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: stored flags, trap outstanding / waiting for ack drop, event count
  logic [3:0] mFlags = '0;
  bit         mTrapOut = 1'b0;
  bit         mAwaitAckLow = 1'b0;
  int         mCount = 0;

  function automatic logic condTable(input logic [3:0] f, input logic [3:0] c);
    logic n, z, v, k;
    {n, z, v, k} = f;
    case (c)
      4'b0000: return 1'b0;
      4'b0001: return z;
      4'b0010: return z | (n ^ v);
      4'b0011: return n ^ v;
      4'b0100: return k | z;
      4'b0101: return k;
      4'b0110: return n;
      4'b0111: return v;
      4'b1000: return 1'b1;
      4'b1001: return ~z;
      4'b1010: return ~(z | (n ^ v));
      4'b1011: return ~(n ^ v);
      4'b1100: return ~(k | z);
      4'b1101: return ~k;
      4'b1110: return ~n;
      default: return ~v;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("flags",  {28'd0, flagsOut}, {28'd0, e.flags});
      check("trap",   {31'd0, trapOut},  {31'd0, e.trap});
      check("count",  {28'd0, countOut}, {28'd0, e.count});
      check("branch", {31'd0, branchOut}, {31'd0, e.branch});
    end
  end

  task automatic drive(input logic ld, input logic [3:0] sel, input logic [3:0] nzvc,
                       input logic [3:0] c, input logic en, input logic ack, input logic clr);
    bit ovf;
    @(negedge clk);
    #1;
    load = ld; aluSel = sel; {inN, inZ, inV, inC} = nzvc; cond = c;
    trapEn = en; trapAck = ack; cntClr = clr;
    ovf = ld && (sel == 4'd3) && nzvc[1];
    if (ld && sel == 4'd3)      mFlags = nzvc;
    else if (ld && sel < 4'd3)  mFlags = {nzvc[3:2], 2'b00};
    if (mTrapOut) begin
      if (ack) begin mTrapOut = 1'b0; mAwaitAckLow = 1'b1; end
    end else if (mAwaitAckLow) begin
      if (!ack) mAwaitAckLow = 1'b0;
    end else if (ovf && en) begin
      mTrapOut = 1'b1;
    end
    if (clr)      mCount = 0;
    else if (ovf) mCount = (mCount + 1 > 15) ? 15 : mCount + 1;
    sbq.push_back('{flags: mFlags, trap: mTrapOut, count: mCount[3:0],
                    branch: condTable(mFlags, c)});
  endtask

  task automatic idle(input int n, input logic [3:0] c, input logic ack);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 4'd0, c, 1'b0, ack, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    load = 1'b0; trapAck = 1'b0; cntClr = 1'b0; trapEn = 1'b0; cond = 4'b1000;
    #1;
    check("rstFlags",  {28'd0, flagsOut}, 32'd0);
    check("rstTrap",   {31'd0, trapOut},  32'd0);
    check("rstCount",  {28'd0, countOut}, 32'd0);
    check("rstBranch", {31'd0, branchOut}, 32'd0);
    mFlags = '0; mTrapOut = 1'b0; mAwaitAckLow = 1'b0; mCount = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    doReset();

    // ADDCC loads all four flags; conditions evaluated on stored flags
    drive(1'b1, 4'd3, 4'b1011, 4'b0011, 1'b0, 1'b0, 1'b0);
    idle(1, 4'b0111, 1'b0);
    // ORCC clears V,C; unassigned selection leaves flags unchanged
    drive(1'b1, 4'd1, 4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd8, 4'b1011, 4'b0001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd15, 4'b1111, 4'b1000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd3, 4'b1111, 4'b0110, 1'b0, 1'b0, 1'b0);

    // Trap handshake; enable drops while pending, second overflow during ack
    drive(1'b1, 4'd3, 4'b0010, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 4'd3, 4'b0010, 4'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(2, 4'd0, 1'b0);

    // Saturating counter, then clear beats simultaneous event
    for (int i = 0; i < 16; i++) drive(1'b1, 4'd3, 4'b0010, 4'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd3, 4'b0010, 4'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd3, 4'b0010, 4'd7, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 4'd3, 4'b0010, 4'd7, 1'b0, 1'b0, 1'b0);

    // Reset while a trap is pending, then trap again from a clean IDLE
    drive(1'b1, 4'd3, 4'b1111, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(1, 4'd0, 1'b0);
    doReset();
    drive(1'b1, 4'd3, 4'b0010, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle(1, 4'd0, 1'b0);

    // Full condition sweep over every flag combination
    for (int f = 0; f < 16; f++) begin
      drive(1'b1, 4'd3, 4'(f), 4'd0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++) idle(1, 4'(c), 1'b0);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 4'($urandom),
            4'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0));
    end

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d expected=0 entries left", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_psr.md
SC_PSR -- requirements
Module: SC_PSR

Interface
REQ-001 SHALL have parameter DATAWIDTH_ALU_SELECTION, default 4, ALU operation-select width.
REQ-002 SHALL have parameter DATAWIDTH_CONDITION, default 4, branch-condition field width.
REQ-003 SHALL have port SC_PSR_CLOCK_50 input 1, single clock; all state on rising edge.
REQ-004 SHALL have port SC_PSR_RESET_InLow input 1, reset, asynchronous, active-low.
REQ-005 SHALL have port SC_PSR_Negative_InHigh input 1, ALU N flag.
REQ-006 SHALL have port SC_PSR_Zero_InHigh input 1, ALU Z flag.
REQ-007 SHALL have port SC_PSR_Overflow_InHigh input 1, ALU V flag.
REQ-008 SHALL have port SC_PSR_Carry_InHigh input 1, ALU C flag.
REQ-009 SHALL have port SC_PSR_ALUSelection_In input DATAWIDTH_ALU_SELECTION, operation driven to ALU this cycle.
REQ-010 SHALL have port SC_PSR_Load_InHigh input 1, ALU result committed this cycle.
REQ-011 SHALL have port SC_PSR_Condition_In input DATAWIDTH_CONDITION, branch condition code.
REQ-012 SHALL have port SC_PSR_TrapEnable_InHigh input 1, overflow-trap enable.
REQ-013 SHALL have port SC_PSR_TrapAck_InHigh input 1, trap acknowledge from control unit.
REQ-014 SHALL have port SC_PSR_CountClear_InHigh input 1, synchronous clear of overflow counter.
REQ-015 SHALL have port SC_PSR_Flags_Out output 4, stored {N,Z,V,C}.
REQ-016 SHALL have port SC_PSR_BranchTaken_OutHigh output 1, condition result.
REQ-017 SHALL have port SC_PSR_TrapRequest_OutHigh output 1, overflow trap request.
REQ-018 SHALL have port SC_PSR_OverflowCount_Out output 4, saturating overflow-event count.

Function
REQ-019 Flag update SHALL occur only on a clock edge with Load=1 and selection in 0000..0011; otherwise flags hold.
REQ-020 Selection 0011 (ADDCC) SHALL load N,Z,V,C from inputs.
REQ-021 Selections 0000/0001/0010 (ANDCC/ORCC/NORCC) SHALL load N,Z from inputs and clear V,C.
REQ-022 Selections 0100..1111 SHALL never change flags, even with Load=1.
REQ-023 BranchTaken SHALL be combinational from stored flags (pre-edge values, not inputs), 0 under reset.
REQ-024 Condition decode SHALL be: 0000 never; 0001 Z; 0010 Z|(N^V); 0011 N^V; 0100 C|Z; 0101 C; 0110 N; 0111 V; 1000 always; 1001 ~Z; 1010 ~(Z|(N^V)); 1011 ~(N^V); 1100 ~(C|Z); 1101 ~C; 1110 ~N; 1111 ~V.
REQ-025 Overflow event SHALL be defined as edge with Load=1, selection 0011, Overflow_InHigh=1.
REQ-026 Trap FSM SHALL have states IDLE, PENDING, RELEASE; TrapRequest=1 only in PENDING (registered, Moore).
REQ-027 IDLE->PENDING on overflow event with TrapEnable=1; else stay IDLE.
REQ-028 PENDING->RELEASE when TrapAck=1; request held indefinitely otherwise; TrapEnable deassertion SHALL NOT cancel a pending request.
REQ-029 RELEASE->IDLE when TrapAck=0; overflow events in PENDING/RELEASE SHALL NOT queue a new trap.
REQ-030 Counter SHALL increment by 1 per overflow event regardless of TrapEnable, saturating at 15 (no wrap).
REQ-031 CountClear SHALL force counter to 0 and SHALL win over a simultaneous increment.
REQ-032 Flags update SHALL proceed in every FSM state.

Reset
REQ-033 Reset assertion SHALL immediately force Flags=0000, counter=0, FSM=IDLE, TrapRequest=0, independent of clock.
REQ-034 Reset mid-trap SHALL drop TrapRequest at once; first edge after release SHALL behave as from IDLE.

Verification
REQ-035 Reset, Load=1 sel=0011 N=1 Z=0 V=1 C=1 -> Flags=1011 next edge; Condition=0011 -> BranchTaken=0 (N^V=0), 0111 -> 1.
REQ-036 Flags=1011, Load=1 sel=0001 N=0 Z=1 V=1 C=1 -> Flags=0100; Load=1 sel=1000 any flags -> Flags stay 0100.
REQ-037 TrapEnable=1, overflow event -> TrapRequest=1 next edge; hold 5 cycles no ack -> still 1; TrapAck=1 -> 0; second overflow during ack -> no new request; TrapAck=0 -> IDLE.
REQ-038 16 consecutive overflow events with TrapEnable=0 -> count 15, TrapRequest=0; CountClear with simultaneous event -> count 0.
REQ-039 Trap PENDING, assert RESET_InLow=0 between edges -> TrapRequest=0 and Flags=0000 before next edge.
REQ-040 Sweep Condition 0000..1111 for each of 16 flag values -> BranchTaken matches REQ-024 table.
